// File: rtl/pkt_pkg.sv
// Shared packet definitions for the serializer and the receive-side parser.
// Byte count, field widths/offsets, field struct, FSM state encoding.
package pkt_pkg;

  localparam int unsigned PAYLOAD_BYTES = 9;
  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned PAYLOAD_W     = PAYLOAD_BYTES * BYTE_W;
  localparam int unsigned CNT_W         = 4;

  localparam int unsigned CMD_W   = 4;
  localparam int unsigned CHAN_W  = 4;
  localparam int unsigned PHASE_W = 21;
  localparam int unsigned WAVE_W  = 2;
  localparam int unsigned FREQ_W  = 20;
  localparam int unsigned CURR_W  = 21;

  localparam int unsigned CURR_LSB  = 0;
  localparam int unsigned FREQ_LSB  = CURR_LSB + CURR_W;
  localparam int unsigned WAVE_LSB  = FREQ_LSB + FREQ_W;
  localparam int unsigned PHASE_LSB = WAVE_LSB + WAVE_W;
  localparam int unsigned CHAN_LSB  = PHASE_LSB + PHASE_W;
  localparam int unsigned CMD_LSB   = CHAN_LSB + CHAN_W;

  typedef struct packed {
    logic [CMD_W-1:0]   cmd;
    logic [CHAN_W-1:0]  channels;
    logic [PHASE_W-1:0] phase;
    logic [WAVE_W-1:0]  waveform;
    logic [FREQ_W-1:0]  frequency;
    logic [CURR_W-1:0]  currents;
  } pkt_fields_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
`ifdef PKT_SER_CKSUM_EN
    CKSUM = 2'd2,
`endif
    SEND  = 2'd1
  } pkt_state_t;

  // Inverse of pkt_pack, for the receive-side parser.
  function automatic pkt_fields_t pkt_unpack(input logic [PAYLOAD_W-1:0] payload);
    pkt_fields_t f;
    f.cmd       = payload[CMD_LSB   +: CMD_W];
    f.channels  = payload[CHAN_LSB  +: CHAN_W];
    f.phase     = payload[PHASE_LSB +: PHASE_W];
    f.waveform  = payload[WAVE_LSB  +: WAVE_W];
    f.frequency = payload[FREQ_LSB  +: FREQ_W];
    f.currents  = payload[CURR_LSB  +: CURR_W];
    return f;
  endfunction

endpackage

// File: rtl/pkt_pack.sv
// Combinational packer: field set -> 72-bit payload at the shared bit offsets.
module pkt_pack
  import pkt_pkg::*;
(
  input  pkt_fields_t          fields,
  output logic [PAYLOAD_W-1:0] payload_c
);

  always_comb begin
    payload_c = '0;
    payload_c[CMD_LSB   +: CMD_W]   = fields.cmd;
    payload_c[CHAN_LSB  +: CHAN_W]  = fields.channels;
    payload_c[PHASE_LSB +: PHASE_W] = fields.phase;
    payload_c[WAVE_LSB  +: WAVE_W]  = fields.waveform;
    payload_c[FREQ_LSB  +: FREQ_W]  = fields.frequency;
    payload_c[CURR_LSB  +: CURR_W]  = fields.currents;
  end

endmodule

// File: rtl/pkt_serializer.sv
// Packs a field set into a 9-byte payload and streams it MSB-first to a UART TX.
// Define PKT_SER_CKSUM_EN to append an XOR checksum byte; only PAYLOAD_BYTES=9 is supported.
module pkt_serializer #(
  parameter int unsigned PAYLOAD_BYTES = 9
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [pkt_pkg::CMD_W-1:0]     pkt_cmd,
  input  logic [pkt_pkg::CHAN_W-1:0]    channels,
  input  logic [pkt_pkg::PHASE_W-1:0]   phase,
  input  logic [pkt_pkg::WAVE_W-1:0]    waveform,
  input  logic [pkt_pkg::FREQ_W-1:0]    frequency,
  input  logic [pkt_pkg::CURR_W-1:0]    currents,
  output logic [pkt_pkg::BYTE_W-1:0]    tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic                          busy,
  output logic                          pkt_sent
);
  import pkt_pkg::*;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PAYLOAD_BYTES - 1);

  pkt_fields_t          fields_c;
  logic [PAYLOAD_W-1:0] payload_c;
  pkt_state_t           state;
  logic [PAYLOAD_W-1:0] shreg;
  logic [CNT_W-1:0]     byte_cnt;
  logic                 accept_c;
  logic                 tx_fire_c;
`ifdef PKT_SER_CKSUM_EN
  logic [BYTE_W-1:0]    cksum;
`endif

  assign fields_c.cmd       = pkt_cmd;
  assign fields_c.channels  = channels;
  assign fields_c.phase     = phase;
  assign fields_c.waveform  = waveform;
  assign fields_c.frequency = frequency;
  assign fields_c.currents  = currents;

  pkt_pack u_pack (
    .fields    (fields_c),
    .payload_c (payload_c)
  );

  assign accept_c  = in_valid && in_ready;
  assign tx_fire_c = tx_valid && tx_ready;

  // The byte on the wire is always the top of the shift register.
  assign tx_data = shreg[PAYLOAD_W-1 -: BYTE_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shreg    <= '0;
      byte_cnt <= '0;
      tx_valid <= 1'b0;
      in_ready <= 1'b1;
      busy     <= 1'b0;
      pkt_sent <= 1'b0;
`ifdef PKT_SER_CKSUM_EN
      cksum    <= '0;
`endif
    end else begin
      pkt_sent <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_c) begin
            shreg    <= payload_c;
            byte_cnt <= '0;
`ifdef PKT_SER_CKSUM_EN
            cksum    <= '0;
`endif
            state    <= SEND;
            tx_valid <= 1'b1;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end

        SEND: begin
          if (tx_fire_c) begin
            shreg <= {shreg[PAYLOAD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
`ifdef PKT_SER_CKSUM_EN
            cksum <= cksum ^ tx_data;
`endif
            if (byte_cnt == LAST_IDX) begin
              byte_cnt <= '0;
`ifdef PKT_SER_CKSUM_EN
              // Checksum byte rides out through the same shift-register top.
              shreg    <= {cksum ^ tx_data, {(PAYLOAD_W-BYTE_W){1'b0}}};
              state    <= CKSUM;
`else
              state    <= IDLE;
              tx_valid <= 1'b0;
              in_ready <= 1'b1;
              busy     <= 1'b0;
              pkt_sent <= 1'b1;
`endif
            end else begin
              byte_cnt <= byte_cnt + CNT_W'(1);
            end
          end
        end

`ifdef PKT_SER_CKSUM_EN
        CKSUM: begin
          if (tx_fire_c) begin
            shreg    <= '0;
            state    <= IDLE;
            tx_valid <= 1'b0;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            pkt_sent <= 1'b1;
          end
        end
`endif

        default: begin
          state    <= IDLE;
          tx_valid <= 1'b0;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_serializer.sv
// Directed bench for pkt_serializer: table of field sets with hand-computed byte streams,
// plus sequences for stalls, back-to-back in_valid and mid-packet reset.
module tb_pkt_serializer;

`ifdef PKT_SER_CKSUM_EN
  localparam int NB = 10;
`else
  localparam int NB = 9;
`endif

  typedef struct {
    logic [3:0]        cmd;
    logic [3:0]        ch;
    logic [20:0]       ph;
    logic [1:0]        wf;
    logic [19:0]       fr;
    logic [20:0]       cu;
    logic [0:9][7:0]   exp;
    int                stall_at;
    int                stall_len;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  pkt_cmd;
  logic [3:0]  channels;
  logic [20:0] phase;
  logic [1:0]  waveform;
  logic [19:0] frequency;
  logic [20:0] currents;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        pkt_sent;

  int total = 0;
  int bad   = 0;
  logic [7:0] got_q[$];
  int sent_cnt = 0;
  vec_t vecs[7];

  pkt_serializer #(.PAYLOAD_BYTES(9)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pkt_cmd   (pkt_cmd),
    .channels  (channels),
    .phase     (phase),
    .waveform  (waveform),
    .frequency (frequency),
    .currents  (currents),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .pkt_sent  (pkt_sent)
  );

  always #5 clk = ~clk;

  // Inputs change #1 after posedge, so a negedge sample predicts the next edge's handshake.
  always @(negedge clk) begin
    if (tx_valid && tx_ready) got_q.push_back(tx_data);
    if (pkt_sent) sent_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    pkt_cmd   = v.cmd;
    channels  = v.ch;
    phase     = v.ph;
    waveform  = v.wf;
    frequency = v.fr;
    currents  = v.cu;
  endtask

  function automatic logic [31:0] got_at(input int idx);
    if (idx < got_q.size()) return 32'(got_q[idx]);
    return 32'hDEAD;
  endfunction

  task automatic send_pkt(input vec_t v, input int id);
    int b = got_q.size();
    int s0 = sent_cnt;
    int stall_left = v.stall_len;
    int cyc = 0;
    @(posedge clk); #1;
    apply(v);
    in_valid = 1'b1;
    tx_ready = 1'b1;
    @(negedge clk);
    while (!in_ready && cyc < 50) begin @(negedge clk); cyc++; end
    chk($sformatf("v%0d in_ready before accept", id), 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk($sformatf("v%0d tx_valid latency", id), 32'(tx_valid), 32'd1);
    chk($sformatf("v%0d in_ready in SEND", id), 32'(in_ready), 32'd0);
    chk($sformatf("v%0d busy in SEND", id), 32'(busy), 32'd1);
    chk($sformatf("v%0d first byte", id), 32'(tx_data), 32'(v.exp[0]));
    cyc = 0;
    while (cyc < 200) begin
      if ((got_q.size() - b) == v.stall_at && stall_left > 0) begin
        tx_ready = 1'b0;
        stall_left--;
      end else begin
        tx_ready = 1'b1;
      end
      @(negedge clk);
      if (!tx_ready) begin
        chk($sformatf("v%0d stall hold data", id), 32'(tx_data), 32'(v.exp[v.stall_at]));
        chk($sformatf("v%0d stall hold valid", id), 32'(tx_valid), 32'd1);
      end
      if (pkt_sent) break;
      @(posedge clk); #1;
      cyc++;
    end
    chk($sformatf("v%0d pkt_sent seen", id), 32'(pkt_sent), 32'd1);
    chk($sformatf("v%0d in_ready with pkt_sent", id), 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk($sformatf("v%0d pkt_sent one cycle", id), 32'(pkt_sent), 32'd0);
    chk($sformatf("v%0d busy idle", id), 32'(busy), 32'd0);
    chk($sformatf("v%0d sent count", id), 32'(sent_cnt - s0), 32'd1);
    chk($sformatf("v%0d handshakes", id), 32'(got_q.size() - b), 32'(NB));
    for (int i = 0; i < NB; i++)
      chk($sformatf("v%0d byte%0d", id, i), got_at(b + i), 32'(v.exp[i]));
  endtask

  initial begin
    int cyc;
    int b;
    int s0;
    vecs[0] = '{4'h1, 4'h2, 21'h0, 2'h0, 20'h0, 21'h0000FF,
                {8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hED}, -1, 0};
    vecs[1] = '{4'h0, 4'h0, 21'h0, 2'b11, 20'h0, 21'h0,
                {8'h00, 8'h00, 8'h00, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h06}, -1, 0};
    vecs[2] = '{4'hF, 4'hF, 21'h1FFFFF, 2'b11, 20'hFFFFF, 21'h1FFFFF,
                {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, -1, 0};
    vecs[3] = '{4'h0, 4'h0, 21'h1FFFFF, 2'h0, 20'h0, 21'h0,
                {8'h00, 8'hFF, 8'hFF, 8'hF8, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF8}, -1, 0};
    vecs[4] = '{4'h0, 4'h0, 21'h0, 2'h0, 20'hFFFFF, 21'h0,
                {8'h00, 8'h00, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'hE0, 8'h00, 8'h00, 8'hE1}, -1, 0};
    vecs[5] = '{4'h0, 4'h0, 21'h0, 2'h0, 20'h0, 21'h1FFFFF,
                {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h1F, 8'hFF, 8'hFF, 8'h1F}, -1, 0};
    vecs[6] = '{4'hA, 4'h5, 21'h0, 2'h0, 20'hFFFFF, 21'h0,
                {8'hA5, 8'h00, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'hE0, 8'h00, 8'h00, 8'h44}, 3, 5};

    rst_n = 1'b0;
    in_valid = 1'b0;
    tx_ready = 1'b0;
    apply(vecs[2]);
    #17;
    chk("reset tx_valid", 32'(tx_valid), 32'd0);
    chk("reset tx_data", 32'(tx_data), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset pkt_sent", 32'(pkt_sent), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready after reset", 32'(in_ready), 32'd1);

    // tx_ready while idle must not start anything
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle tx_ready tx_valid", 32'(tx_valid), 32'd0);
    chk("idle tx_ready no bytes", 32'(got_q.size()), 32'd0);

    for (int i = 0; i < 7; i++) send_pkt(vecs[i], i);

    // in_valid held across two field sets
    b = got_q.size();
    s0 = sent_cnt;
    @(posedge clk); #1;
    apply(vecs[0]);
    in_valid = 1'b1;
    tx_ready = 1'b1;
    @(posedge clk); #1;
    apply(vecs[3]);
    chk("b2b first accepted", 32'(tx_valid), 32'd1);
    cyc = 0;
    @(negedge clk);
    while (!pkt_sent && cyc < 100) begin @(negedge clk); cyc++; end
    chk("b2b first pkt_sent", 32'(pkt_sent), 32'd1);
    chk("b2b gap tx_valid", 32'(tx_valid), 32'd0);
    chk("b2b in_ready with pkt_sent", 32'(in_ready), 32'd1);
    chk("b2b first length", 32'(got_q.size() - b), 32'(NB));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b second accepted", 32'(tx_valid), 32'd1);
    chk("b2b second byte0", 32'(tx_data), 32'(vecs[3].exp[0]));
    cyc = 0;
    @(negedge clk);
    while (!pkt_sent && cyc < 100) begin @(negedge clk); cyc++; end
    chk("b2b second pkt_sent", 32'(pkt_sent), 32'd1);
    @(posedge clk); #1;
    chk("b2b sent count", 32'(sent_cnt - s0), 32'd2);
    chk("b2b total bytes", 32'(got_q.size() - b), 32'(2 * NB));
    for (int i = 0; i < NB; i++) begin
      chk($sformatf("b2b A byte%0d", i), got_at(b + i), 32'(vecs[0].exp[i]));
      chk($sformatf("b2b B byte%0d", i), got_at(b + NB + i), 32'(vecs[3].exp[i]));
    end

    // reset after three bytes aborts the packet
    b = got_q.size();
    s0 = sent_cnt;
    @(posedge clk); #1;
    apply(vecs[2]);
    in_valid = 1'b1;
    tx_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while ((got_q.size() - b) < 3 && cyc < 50) begin @(posedge clk); #1; cyc++; end
    chk("abort bytes before reset", 32'(got_q.size() - b), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("abort tx_valid", 32'(tx_valid), 32'd0);
    chk("abort tx_data", 32'(tx_data), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    chk("abort no more bytes", 32'(got_q.size() - b), 32'd3);
    chk("abort no pkt_sent", 32'(sent_cnt - s0), 32'd0);
    chk("abort in_ready", 32'(in_ready), 32'd1);
    send_pkt(vecs[1], 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pkt_serializer.md
PKT_SERIALIZER -- requirements
Module: pkt_serializer

Interface
REQ-001 Parameter: PAYLOAD_BYTES, default 9, payload length in bytes; only 9 is supported.
REQ-002 Port: clk  input  1  single clock; all logic on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: in_valid  input  1  field set presented.
REQ-005 Port: in_ready  output  1  block accepts a field set.
REQ-006 Port: pkt_cmd  input  4  command field.
REQ-007 Port: channels  input  4  channel mask.
REQ-008 Port: phase  input  21  phase field.
REQ-009 Port: waveform  input  2  waveform select.
REQ-010 Port: frequency  input  20  frequency field.
REQ-011 Port: currents  input  21  currents field.
REQ-012 Port: tx_data  output  8  byte to UART TX.
REQ-013 Port: tx_valid  output  1  tx_data valid.
REQ-014 Port: tx_ready  input  1  UART TX accepts byte.
REQ-015 Port: busy  output  1  packet in flight (state != IDLE).
REQ-016 Port: pkt_sent  output  1  1-cycle pulse after the final byte is accepted.

Function
REQ-017 The payload SHALL be packed MSB->LSB as [71:68] cmd, [67:64] channels, [63:43] phase, [42:41] waveform, [40:21] frequency, [20:0] currents.
REQ-018 The FSM SHALL have states IDLE, SEND, CKSUM (CKSUM only with the macro in REQ-030).
REQ-019 in_ready SHALL be 1 in IDLE only; in_valid outside IDLE SHALL be ignored.
REQ-020 On in_valid && in_ready: latch packed payload into a 72-bit shift register, clear byte counter and checksum, go to SEND.
REQ-021 tx_valid SHALL rise the cycle after acceptance (1-cycle latency) and SHALL be 1 throughout SEND/CKSUM.
REQ-022 In SEND, tx_data SHALL be shreg[71:64]; bytes go out MSB first, byte 0 = payload[71:64].
REQ-023 On tx_valid && tx_ready in SEND: shift shreg left 8, increment counter, XOR the byte into the checksum.
REQ-024 tx_data SHALL remain stable while tx_valid && !tx_ready (no byte dropped or repeated).
REQ-025 After the 9th accepted byte (counter wraps 8->0), go to CKSUM if enabled, else to IDLE.
REQ-026 pkt_sent SHALL pulse for exactly one cycle, in the cycle after the final byte handshake; in_ready returns 1 in the same cycle (back-to-back packets allowed, min 1 idle cycle).
REQ-027 tx_ready while tx_valid=0 SHALL have no effect.

Reset
REQ-028 On rst_n=0, asynchronously: state=IDLE, tx_valid=0, tx_data=0, busy=0, pkt_sent=0, counter/shreg/checksum=0; in_ready=1 after release.
REQ-029 Reset mid-packet SHALL abort it; no remaining bytes and no pkt_sent are emitted after release.

Configuration
REQ-030 Macro PKT_SER_CKSUM_EN defined: after byte 9, CKSUM state emits one byte = XOR of the 9 payload bytes, then IDLE and pkt_sent; undefined: CKSUM state and checksum register absent, 9 bytes per packet.

Structure
REQ-031 Package pkt_pkg SHALL hold PAYLOAD_BYTES, field widths/bit offsets, packed struct pkt_fields_t, and the FSM state enum, shared with the receive-side parser.
REQ-032 Sub-module pkt_pack (combinational pkt_fields_t -> 72-bit payload) SHALL be instantiated; the receive side uses the same offsets.

Verification
REQ-033 cmd=1, channels=2, currents=21'h0000FF, others 0, tx_ready=1 -> bytes 12 00 00 00 00 00 00 00 FF (+ED with checksum), pkt_sent once.
REQ-034 waveform=2'b11, others 0 -> byte3=06, all other bytes 00; checks bits 42:41.
REQ-035 tx_ready low 5 cycles on byte 4 -> tx_data held constant, sequence intact, total 9 (10) handshakes.
REQ-036 in_valid held high continuously with two different field sets -> second accepted only when in_ready=1 after pkt_sent; no overlap.
REQ-037 rst_n pulsed low after byte 3 -> tx_valid=0 immediately, no pkt_sent, next packet starts at byte 0.
REQ-038 All fields max (cmd=F..currents=1FFFFF) -> nine FF bytes (checksum FF^..^FF = FF).
